// File: rtl/vce_video_timing.sv
// Raster timing generator: dot strobe, line/frame counters, sync and blank decodes.
// Latency: all outputs are combinational decodes of the registered counters (no extra stage).
// Backpressure: none; free-running once out of reset, counters hold only while not yet running.
module vce_video_timing #(
    parameter int H_TOTAL        = 1365,
    parameter int HSYNC_CLKS     = 104,
    parameter int H_ACTIVE_START = 264,
    parameter int H_ACTIVE_CLKS  = 1024,
    parameter int VSYNC_LINES    = 3,
    parameter int V_ACTIVE_START = 14,
    parameter int V_ACTIVE_LINES = 242
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  dot_mode,
    input  logic        frame_263,
    output logic        dot_en,
    output logic        HSYNC_n,
    output logic        VSYNC_n,
    output logic        hblank,
    output logic        vblank,
    output logic [10:0] h_count,
    output logic [9:0]  dot_x,
    output logic [8:0]  line_y,
    output logic        line_start,
    output logic        frame_start
);

    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] HS_END   = 11'(HSYNC_CLKS);
    localparam logic [10:0] HA_START = 11'(H_ACTIVE_START);
    localparam logic [10:0] HA_END   = 11'(H_ACTIVE_START + H_ACTIVE_CLKS);
    localparam logic [8:0]  VS_END   = 9'(VSYNC_LINES);
    localparam logic [8:0]  VA_START = 9'(V_ACTIVE_START);
    localparam logic [8:0]  VA_END   = 9'(V_ACTIVE_START + V_ACTIVE_LINES);

    logic       running;
    logic [1:0] div_cnt;
    logic [1:0] mode_act;   // divisor in force for the current line
    logic       f263_act;   // frame length in force for the current frame
    logic       h_end;
    logic [8:0] last_line;
    logic [1:0] div_last;

    assign h_end     = (h_count == H_LAST);
    assign last_line = f263_act ? 9'd262 : 9'd261;
    // Terminal value of the dot phase counter: N-1 for divisor N (4/3/2).
    assign div_last  = (mode_act == 2'd0) ? 2'd3 :
                       (mode_act == 2'd1) ? 2'd2 : 2'd1;

    // Run flag: first edge out of reset arms the scan; counters stay at (0,0) on that edge.
    always_ff @(posedge clock) begin
        if (reset) running <= 1'b0;
        else       running <= 1'b1;
    end

    // Horizontal position and per-line mode latch (mode only changes at a line boundary).
    always_ff @(posedge clock) begin
        if (reset) begin
            h_count  <= '0;
            mode_act <= dot_mode;
        end else if (running) begin
            if (h_end) begin
                h_count  <= '0;
                mode_act <= dot_mode;
            end else begin
                h_count  <= h_count + 11'd1;
            end
        end
    end

    // Line counter and per-frame length latch (length only changes at a frame boundary).
    always_ff @(posedge clock) begin
        if (reset) begin
            line_y   <= '0;
            f263_act <= frame_263;
        end else if (running && h_end) begin
            if (line_y == last_line) begin
                line_y   <= '0;
                f263_act <= frame_263;
            end else begin
                line_y   <= line_y + 9'd1;
            end
        end
    end

    // Dot phase and dot index; both realign to zero at the start of every line.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt <= '0;
            dot_x   <= '0;
        end else if (running) begin
            if (h_end) begin
                div_cnt <= '0;
                dot_x   <= '0;
            end else begin
                div_cnt <= (div_cnt == div_last) ? 2'd0 : div_cnt + 2'd1;
                if (dot_en) dot_x <= dot_x + 10'd1;
            end
        end
    end

    assign dot_en      = running && (div_cnt == 2'd0);
    assign HSYNC_n     = !(running && (h_count < HS_END));
    assign VSYNC_n     = !(running && (line_y < VS_END));
    assign hblank      = !(running && (h_count >= HA_START) && (h_count < HA_END));
    assign vblank      = !(running && (line_y >= VA_START) && (line_y < VA_END));
    assign line_start  = running && (h_count == 11'd0);
    assign frame_start = running && (h_count == 11'd0) && (line_y == 9'd0);

endmodule
